// File: rtl/pc_gen.sv
// Purpose: fetch-stage program counter with flush/branch/sequential next-PC selection and a one-deep branch park.
// Latency: flush or branch presented in cycle N appears on pc after edge N+1; all outputs registered.
// Backpressure: stall[0] holds pc; a branch seen while stalled is parked and replayed on the first unstalled edge.
module pc_gen #(
    parameter int unsigned        ADDR_W       = 32,
    parameter logic [ADDR_W-1:0]  RESET_VECTOR = ADDR_W'(32'hBFC0_0000),
    parameter int unsigned        STEP         = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [5:0]        stall,
    input  logic              flush,
    input  logic [ADDR_W-1:0] flush_addr,
    input  logic              branch_flag_in,
    input  logic [ADDR_W-1:0] branch_tar_addr_in,
    output logic [ADDR_W-1:0] pc,
    output logic              ce,
    output logic              pc_misaligned,
    output logic              redirected
);

    localparam logic [ADDR_W-1:0] STEP_V    = ADDR_W'(STEP);
    localparam logic [ADDR_W-1:0] STEP_MASK = ADDR_W'(STEP - 1);

    // RESET: ce low; RUN: nothing parked; PEND: a stalled branch is waiting in pend_addr
    typedef enum logic [1:0] {
        ST_RESET = 2'd0,
        ST_RUN   = 2'd1,
        ST_PEND  = 2'd2
    } state_t;

    state_t            state;
    state_t            state_nxt;
    logic [ADDR_W-1:0] pend_addr;
    logic [ADDR_W-1:0] pend_addr_nxt;
    logic [ADDR_W-1:0] pc_nxt;
    logic              redir_nxt;

    // Only the fetch stall bit matters here; the upper bits belong to later stages.
    logic unused_stall;
    assign unused_stall = ^stall[5:1];

    // Next-PC selection: flush beats everything, a parked branch beats a fresh one.
    always_comb begin
        state_nxt     = state;
        pend_addr_nxt = pend_addr;
        pc_nxt        = pc;
        redir_nxt     = 1'b0;
        if (state == ST_RESET) begin
            // ce was low at this edge, so inputs are ignored and pc stays on the vector
            pc_nxt    = RESET_VECTOR;
            state_nxt = ST_RUN;
        end else if (flush) begin
            pc_nxt    = flush_addr;
            state_nxt = ST_RUN;
            redir_nxt = 1'b1;
        end else if (stall[0]) begin
            // Park only the first branch; later ones during the same stall are dropped
            if (branch_flag_in && (state == ST_RUN)) begin
                pend_addr_nxt = branch_tar_addr_in;
                state_nxt     = ST_PEND;
            end
        end else if (state == ST_PEND) begin
            pc_nxt    = pend_addr;
            state_nxt = ST_RUN;
            redir_nxt = 1'b1;
        end else if (branch_flag_in) begin
            pc_nxt    = branch_tar_addr_in;
            redir_nxt = 1'b1;
        end else begin
            pc_nxt = pc + STEP_V;
        end
    end

    // State and registered outputs; synchronous active-low reset discards any parked branch.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state         <= ST_RESET;
            ce            <= 1'b0;
            pc            <= RESET_VECTOR;
            pend_addr     <= '0;
            redirected    <= 1'b0;
            pc_misaligned <= (RESET_VECTOR & STEP_MASK) != '0;
        end else begin
            state         <= state_nxt;
            ce            <= 1'b1;
            pc            <= pc_nxt;
            pend_addr     <= pend_addr_nxt;
            redirected    <= redir_nxt;
            pc_misaligned <= (pc_nxt & STEP_MASK) != '0;
        end
    end

endmodule

// File: tb/tb_pc_gen.sv
// Purpose: self-checking bench for pc_gen, directed test-plan cases plus random traffic against a reference model.
// Latency: outputs sampled 1 time unit after each rising edge.
// Backpressure: stall is driven both directed and randomly.
module tb_pc_gen;

    localparam logic [31:0] RV32 = 32'hBFC0_0000;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // 32-bit, STEP=4 instance
    logic        rst;
    logic [5:0]  stall;
    logic        flush;
    logic [31:0] flush_addr;
    logic        br;
    logic [31:0] tar;
    logic [31:0] pc;
    logic        ce;
    logic        mis;
    logic        redir;

    // 16-bit, STEP=8 instance (reset vector truncates to 16'h0000)
    logic [5:0]  stall16;
    logic        flush16;
    logic [15:0] fa16;
    logic        br16;
    logic [15:0] tar16;
    logic [15:0] pc16;
    logic        ce16;
    logic        mis16;
    logic        redir16;

    pc_gen dut (
        .clk(clk), .rst(rst), .stall(stall), .flush(flush), .flush_addr(flush_addr),
        .branch_flag_in(br), .branch_tar_addr_in(tar),
        .pc(pc), .ce(ce), .pc_misaligned(mis), .redirected(redir)
    );

    pc_gen #(.ADDR_W(16), .STEP(8)) dut16 (
        .clk(clk), .rst(rst), .stall(stall16), .flush(flush16), .flush_addr(fa16),
        .branch_flag_in(br16), .branch_tar_addr_in(tar16),
        .pc(pc16), .ce(ce16), .pc_misaligned(mis16), .redirected(redir16)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Reference model of the 32-bit instance: the pending branch is a queue holding at most one target.
    logic [31:0] m_pc = RV32;
    bit          m_ce = 1'b0;
    bit          m_redir = 1'b0;
    bit          m_mis = 1'b0;
    logic [31:0] m_pend[$];

    task automatic model_edge();
        if (!rst) begin
            m_ce = 1'b0; m_pc = RV32; m_pend.delete(); m_redir = 1'b0;
        end else if (!m_ce) begin
            m_ce = 1'b1; m_pc = RV32; m_pend.delete(); m_redir = 1'b0;
        end else if (flush) begin
            m_pc = flush_addr; m_pend.delete(); m_redir = 1'b1;
        end else if (stall[0]) begin
            if (br && m_pend.size() == 0) m_pend.push_back(tar);
            m_redir = 1'b0;
        end else if (m_pend.size() != 0) begin
            m_pc = m_pend.pop_front(); m_redir = 1'b1;
        end else if (br) begin
            m_pc = tar; m_redir = 1'b1;
        end else begin
            m_pc = 32'((64'(m_pc) + 64'd4) % 64'h1_0000_0000); m_redir = 1'b0;
        end
        m_mis = (m_pc % 4) != 0;
    endtask

    // One clock: model follows the edge, DUT is sampled shortly after it.
    task automatic cycle();
        @(posedge clk);
        model_edge();
        #1;
        chk("m_pc", pc, m_pc);
        chk("m_ce", 32'(ce), 32'(m_ce));
        chk("m_mis", 32'(mis), 32'(m_mis));
        chk("m_redir", 32'(redir), 32'(m_redir));
    endtask

    initial begin
        rst = 1'b0; stall = '0; flush = 1'b0; flush_addr = '0; br = 1'b0; tar = '0;
        stall16 = '0; flush16 = 1'b0; fa16 = '0; br16 = 1'b0; tar16 = '0;

        // Reset and release
        cycle(); cycle();
        chk("rst_ce", 32'(ce), 32'd0);
        chk("rst_pc", pc, RV32);
        chk("rst_redir", 32'(redir), 32'd0);
        chk("rst_mis", 32'(mis), 32'd0);
        chk("rst_pc16", 32'(pc16), 32'h0000);
        rst = 1'b1;
        cycle();
        chk("rel_ce", 32'(ce), 32'd1);
        chk("rel_pc", pc, RV32);
        cycle();
        chk("seq1_pc", pc, 32'hBFC0_0004);
        chk("seq1_redir", 32'(redir), 32'd0);
        cycle();
        chk("seq2_pc", pc, 32'hBFC0_0008);

        // Unstalled branch
        br = 1'b1; tar = 32'h0040_0100;
        cycle();
        br = 1'b0;
        chk("br_pc", pc, 32'h0040_0100);
        chk("br_redir", 32'(redir), 32'd1);
        cycle();
        chk("br_next_pc", pc, 32'h0040_0104);
        chk("br_next_redir", 32'(redir), 32'd0);

        // Branch during a 3-cycle stall, replayed on release
        stall = 6'b000001; br = 1'b1; tar = 32'h0000_0040;
        cycle();
        br = 1'b0;
        cycle(); cycle();
        chk("stall_hold_pc", pc, 32'h0040_0104);
        stall = '0;
        cycle();
        chk("pend_pc", pc, 32'h0000_0040);
        chk("pend_redir", 32'(redir), 32'd1);

        // Flush while a branch is parked discards it
        stall = 6'b000001; br = 1'b1; tar = 32'h0000_0040;
        cycle();
        br = 1'b0; flush = 1'b1; flush_addr = 32'h8000_0180;
        cycle();
        flush = 1'b0;
        chk("flush_pc", pc, 32'h8000_0180);
        chk("flush_redir", 32'(redir), 32'd1);
        cycle();
        chk("flush_hold_pc", pc, 32'h8000_0180);
        stall = '0;
        cycle();
        chk("flush_after_pc", pc, 32'h8000_0184);

        // Misaligned target is loaded as-is and flagged
        br = 1'b1; tar = 32'h0000_0102;
        cycle();
        br = 1'b0;
        chk("mis_pc", pc, 32'h0000_0102);
        chk("mis_flag", 32'(mis), 32'd1);
        cycle();
        chk("mis_inc_pc", pc, 32'h0000_0106);
        chk("mis_inc_flag", 32'(mis), 32'd1);
        flush = 1'b1; flush_addr = 32'h0000_0200;
        cycle();
        flush = 1'b0;
        chk("mis_clr_pc", pc, 32'h0000_0200);
        chk("mis_clr_flag", 32'(mis), 32'd0);

        // 32-bit wrap-around
        br = 1'b1; tar = 32'hFFFF_FFFC;
        cycle();
        br = 1'b0;
        cycle();
        chk("wrap_pc", pc, 32'h0000_0000);
        chk("wrap_redir", 32'(redir), 32'd0);

        // 16-bit / STEP=8 wrap and misalignment
        br16 = 1'b1; tar16 = 16'hFFF8;
        cycle();
        br16 = 1'b0;
        chk("w16_pc", 32'(pc16), 32'h0000_FFF8);
        chk("w16_redir", 32'(redir16), 32'd1);
        cycle();
        chk("w16_wrap_pc", 32'(pc16), 32'h0000_0000);
        chk("w16_wrap_mis", 32'(mis16), 32'd0);
        br16 = 1'b1; tar16 = 16'h0004;
        cycle();
        br16 = 1'b0;
        chk("w16_mis", 32'(mis16), 32'd1);
        cycle();
        chk("w16_mis_inc_pc", 32'(pc16), 32'h0000_000C);

        // Reset while a branch is parked: it must not reappear
        stall = 6'b000001; br = 1'b1; tar = 32'h0000_0040;
        cycle();
        br = 1'b0; rst = 1'b0;
        cycle();
        chk("rp_ce", 32'(ce), 32'd0);
        chk("rp_pc", pc, RV32);
        rst = 1'b1; stall = '0;
        cycle();
        chk("rp_rel_pc", pc, RV32);
        chk("rp_rel_ce", 32'(ce), 32'd1);
        cycle();
        chk("rp_seq_pc", pc, 32'hBFC0_0004);
        chk("rp_seq_redir", 32'(redir), 32'd0);

        // Random traffic against the model
        for (int i = 0; i < 3000; i++) begin
            rst        = ($urandom_range(0, 99) != 0);
            stall      = 6'($urandom);
            stall[0]   = ($urandom_range(0, 9) < 4);
            flush      = ($urandom_range(0, 19) == 0);
            flush_addr = $urandom;
            br         = ($urandom_range(0, 4) == 0);
            tar        = ($urandom_range(0, 3) == 0) ? $urandom : ($urandom & 32'hFFFF_FFFC);
            cycle();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/pc_gen.md
# pc_gen

Parametrised program-counter generator for the MIPS32 fetch stage, successor to the single-width PC register. It produces the registered fetch address and instruction-memory chip enable. It arbitrates three next-PC sources: exception/flush redirect from ctrl, branch target from decode, and sequential increment. It also buffers a branch that arrives while fetch is stalled, so the redirect is not lost, and flags misaligned fetch addresses.

## Interface
- ADDR_W, 32, width of PC and all address inputs.
- RESET_VECTOR, 32'hBFC0_0000 truncated to ADDR_W, first fetch address after reset.
- STEP, 4, sequential increment in bytes; power of two, 4 or 8.
- clk  in  1  sole clock; all state updates on rising edge.
- rst  in  1  synchronous reset, active-low: rst==0 at a rising edge resets the block.
- stall  in  6  pipeline stall vector from ctrl; only stall[0] is used (1 = hold PC).
- flush  in  1  exception/eret redirect from ctrl; highest priority.
- flush_addr  in  ADDR_W  redirect target, valid with flush.
- branch_flag_in  in  1  taken branch/jump from decode.
- branch_tar_addr_in  in  ADDR_W  branch target, valid with branch_flag_in.
- pc  out  ADDR_W  current fetch address, registered.
- ce  out  1  instruction memory enable, registered.
- pc_misaligned  out  1  registered; 1 when pc mod STEP != 0.
- redirected  out  1  registered one-cycle pulse; pc came from flush or branch, not increment.

## Operation
- ce pipeline: ce <= 0 while rst==0, else 1. It lags rst release by one edge.
- Internal state: pend_valid (1 bit) and pend_addr (ADDR_W).
- Next-PC priority, evaluated every edge with ce==1:
  1. flush: pc <= flush_addr; clear pend_valid; redirected <= 1. Applies regardless of stall[0].
  2. stall[0]==1: pc holds.
     - If branch_flag_in and !pend_valid, capture pend_addr <= branch_tar_addr_in and set pend_valid.
     - If pend_valid is already set, an incoming branch is ignored.
     - redirected <= 0.
  3. stall[0]==0, pend_valid: pc <= pend_addr; clear pend_valid; redirected <= 1. A simultaneous branch_flag_in is ignored.
  4. stall[0]==0, branch_flag_in: pc <= branch_tar_addr_in; redirected <= 1.
  5. Otherwise: pc <= pc + STEP, modulo 2^ADDR_W with no carry out; redirected <= 0.
- Edge with ce==0: pc <= RESET_VECTOR, pend_valid <= 0, redirected <= 0. Inputs are ignored.
- pc_misaligned <= (next pc value) mod STEP != 0.
  - Targets are loaded unmodified; no alignment correction is applied.
  - Exception generation belongs to downstream stages.
- States: RESET (ce=0), RUN (pend_valid=0), PEND (pend_valid=1).
  - RESET -> RUN on the first edge with rst==1.
  - RUN -> PEND on a stalled branch.
  - PEND -> RUN on the first unstalled edge, or on flush.
  - Any state -> RESET on rst==0.

## Timing
- Reset values (after any edge with rst==0): ce=0, pc=RESET_VECTOR, pend_valid=0, pc_misaligned=RESET_VECTOR mod STEP != 0, redirected=0.
- First edge with rst==1: ce becomes 1; pc stays RESET_VECTOR, because ce was 0 at that edge.
- Second edge with rst==1: first update by the priority rules.
- Latency: flush or branch presented in cycle N appears on pc after edge N+1. The decode delay slot is fetched at the increment of edge N.
- A pending branch is applied on the first edge with stall[0]==0, one edge after stall release.
- Reset mid-operation (rst==0 with pend_valid=1 or flush asserted): reset wins and the pending branch is discarded.
- Wrap-around: pc = 2^ADDR_W - STEP increments to 0 with no flag.
- All outputs are registered; no combinational path from inputs to outputs.

## Test plan
- Reset release, RESET_VECTOR=32'hBFC00000, no stall -> ce 0→1 one edge after rst high. pc reads BFC00000 for that cycle, then BFC00004 and BFC00008; redirected=0.
- Branch to 32'h00400100 with stall[0]=0 -> pc=00400100 on the next edge with redirected=1, then 00400104 with redirected=0.
- stall[0]=1 for 3 cycles, branch to 32'h00000040 in the first stalled cycle -> pc holds. On the first unstalled edge pc=00000040 and redirected=1.
- While pending (target 0x40), assert flush with flush_addr=32'h80000180 under stall -> pc=80000180. After stall release the next pc is 80000184; 0x40 never appears.
- Branch to 32'h00000102 -> pc=00000102 with pc_misaligned=1; the next increment gives 00000106, still misaligned. Flush to 0x200 clears the flag.
- ADDR_W=16, STEP=8, pc=16'hFFF8 unstalled -> pc=16'h0000. Also: rst low while pending -> pc=RESET_VECTOR, ce=0, and the pending branch is not applied.
